pixel_sink: RTL



---
 rtl/pixel_pkg.sv | 33 +++
 rtl/pixel_sink_if.sv | 40 ++++
 rtl/pixel_fifo.sv | 53 +++++
 rtl/pixel_sink.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared screen constants, pixel beat type, output FSM states and
// the clip/address helpers used by pixel_sink.
// Build option: PIXEL_SINK_CLEAR_EN adds the CLEAR state.
package pixel_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 4;
  localparam int ADDR_W   = 17;

  typedef struct packed {
    logic [8:0]          x;
    logic [8:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_beat_t;

`ifdef PIXEL_SINK_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} sink_state_t;
`else
  typedef enum logic {ST_IDLE, ST_WRITE} sink_state_t;
`endif

  // True when the beat lands inside the visible screen.
  function automatic logic on_screen(input pixel_beat_t b);
    return (b.x < 9'(SCREEN_W)) && (b.y < 9'(SCREEN_H));
  endfunction

  // Row-major framebuffer address, widened to ADDR_W before the multiply.
  function automatic logic [ADDR_W-1:0] pixel_addr(input pixel_beat_t b);
    return ADDR_W'(b.y) * ADDR_W'(SCREEN_W) + ADDR_W'(b.x);
  endfunction

endpackage

// File: rtl/pixel_sink_if.sv
// pixel_sink_if: pixel beat input, framebuffer write port and status of the
// pixel sink. slave = pixel_sink side, master = drawing/memory side.
// Build option: PIXEL_SINK_CLEAR_EN adds clear_req/clear_busy.
interface pixel_sink_if;
  import pixel_pkg::*;

  logic                writeEn;
  logic [8:0]          x;
  logic [8:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_busy;
  logic [15:0]         clip_count;
  logic                overflow;
`ifdef PIXEL_SINK_CLEAR_EN
  logic                clear_req;
  logic                clear_busy;

  modport slave (
    input  writeEn, x, y, colour, mem_busy, clear_req,
    output ready, mem_we, mem_addr, mem_data, clip_count, overflow, clear_busy
  );
  modport master (
    output writeEn, x, y, colour, mem_busy, clear_req,
    input  ready, mem_we, mem_addr, mem_data, clip_count, overflow, clear_busy
  );
`else
  modport slave (
    input  writeEn, x, y, colour, mem_busy,
    output ready, mem_we, mem_addr, mem_data, clip_count, overflow
  );
  modport master (
    output writeEn, x, y, colour, mem_busy,
    input  ready, mem_we, mem_addr, mem_data, clip_count, overflow
  );
`endif
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with first-word-fall-through read data.
// A push while full is dropped even if a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage.
  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_sink.sv
// pixel_sink: buffers pixel beats, drops off-screen ones, and issues
// single-beat framebuffer writes that wait out mem_busy.
// Build option: PIXEL_SINK_CLEAR_EN adds a full-screen clear sequence.
module pixel_sink
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic         clock,
  input logic         reset,
  pixel_sink_if.slave sink
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  pixel_beat_t       push_beat, head_beat;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_count;

  sink_state_t       state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [COLOUR_W-1:0] mem_data_q;
  logic [15:0]       clip_count_q, clip_count_d;
  logic              overflow_q;

  logic              ready, clearing, hold_for_clear;
  logic              load_slot, load_beat, head_visible;
  logic [ADDR_W-1:0] head_addr;

`ifdef PIXEL_SINK_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  logic clear_pend_q;
  assign clearing       = (state_q == ST_CLEAR);
  assign hold_for_clear = sink.clear_req || clear_pend_q;
  assign sink.clear_busy = clearing;
`else
  assign clearing       = 1'b0;
  assign hold_for_clear = 1'b0;
`endif

  assign push_beat    = '{x: sink.x, y: sink.y, colour: sink.colour};
  assign ready        = !fifo_full && !clearing;
  assign fifo_push    = sink.writeEn && ready;
  assign unused_count = ^fifo_count;

  // The output slot frees up when idle or when the current write completes.
  assign load_slot    = ((state_q == ST_IDLE) ||
                         (state_q == ST_WRITE && !sink.mem_busy)) && !hold_for_clear;
  assign fifo_pop     = load_slot && !fifo_empty;
  assign head_visible = on_screen(head_beat);
  assign load_beat    = fifo_pop && head_visible;
  assign head_addr    = pixel_addr(head_beat);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_beat_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (push_beat),
    .pop_i   (fifo_pop),
    .data_o  (head_beat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Saturating count of beats popped and discarded as off-screen.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    clip_count_d = clip_count_q;
    if (fifo_pop && !head_visible && clip_count_q != 16'hFFFF)
      clip_count_d = clip_count_q + 16'd1;
  end

  // Output FSM with registered write strobe, address and data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      clip_count_q <= '0;
`ifdef PIXEL_SINK_CLEAR_EN
      clear_pend_q <= 1'b0;
`endif
    end else begin
      clip_count_q <= clip_count_d;
      case (state_q)
        ST_IDLE: begin
`ifdef PIXEL_SINK_CLEAR_EN
          if (hold_for_clear) begin
            state_q      <= ST_CLEAR;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            clear_pend_q <= 1'b0;
          end else
`endif
          if (load_beat) begin
            state_q    <= ST_WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= head_addr;
            mem_data_q <= head_beat.colour;
          end
        end
        ST_WRITE: begin
          if (!sink.mem_busy) begin
            if (load_beat) begin
              mem_addr_q <= head_addr;
              mem_data_q <= head_beat.colour;
            end else begin
              state_q  <= ST_IDLE;
              mem_we_q <= 1'b0;
            end
          end
        end
`ifdef PIXEL_SINK_CLEAR_EN
        ST_CLEAR: begin
          if (!sink.mem_busy) begin
            if (mem_addr_q == LAST_ADDR) begin
              state_q  <= ST_IDLE;
              mem_we_q <= 1'b0;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
        end
`endif
        default: begin
          state_q  <= ST_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
`ifdef PIXEL_SINK_CLEAR_EN
      if (sink.clear_req && state_q == ST_WRITE) clear_pend_q <= 1'b1;
`endif
    end
  end

  // Sticky flag for beats offered while the sink could not take them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          overflow_q <= 1'b0;
    else if (sink.writeEn && !ready)    overflow_q <= 1'b1;
  end

  assign sink.ready      = ready;
  assign sink.mem_we     = mem_we_q;
  assign sink.mem_addr   = mem_addr_q;
  assign sink.mem_data   = mem_data_q;
  assign sink.clip_count = clip_count_q;
  assign sink.overflow   = overflow_q;

endmodule
